// File: rtl/rom_read_arbiter.sv
// Round-robin sharing of a 1-cycle-latency synchronous ROM between NREQ requesters.
// Each accepted read is tagged so its data returns to the issuing requester one cycle later.
module rom_read_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*AW-1:0]         req_addr,
    output logic [NREQ-1:0]            req_ready,
    output logic [AW-1:0]              rom_addr,
    input  logic [DW-1:0]              rom_data,
    output logic [NREQ-1:0]            rsp_valid,
    output logic [DW-1:0]              rsp_data,
    output logic [$clog2(NREQ)-1:0]    dbg_ptr_o
);

    localparam int PW = $clog2(NREQ);

    // Handshake: requester i's read transfers in the cycle req_valid[i] && req_ready[i];
    // req_ready is combinational, one-hot, and never raised for an idle requester.
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   last_addr_q;
    logic [NREQ-1:0] tag_q;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   cand;
    logic            found;

    always_comb begin
        grant = '0;
        gidx  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!reset && !found && req_valid[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (found) begin
            grant[gidx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (int'(gidx) == NREQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gidx + 1'b1;
            end
        end
    end

    // Holding the last issued address keeps the ROM input quiet when nobody is granted.
    always_comb begin
        rom_addr = last_addr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                rom_addr = req_addr[i*AW +: AW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            last_addr_q <= '0;
            tag_q       <= '0;
        end else begin
            ptr_q       <= ptr_d;
            last_addr_q <= rom_addr;
            tag_q       <= grant;
        end
    end

    assign req_ready = grant;
    assign rsp_valid = tag_q;
    assign rsp_data  = rom_data;
    assign dbg_ptr_o = ptr_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Bench for rom_read_arbiter (NREQ=3) with a ROM model and a cycle-level
// reference of the round-robin arbiter written with plain integer arithmetic.
module tb_rom_read_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 8;
  localparam int DW   = 8;
  localparam int PW   = $clog2(NREQ);

  // clock/reset block
  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ-1:0]     req_ready;
  logic [AW-1:0]       rom_addr;
  logic [DW-1:0]       rom_data;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [PW-1:0]       dbg_ptr;

  always #5 clk = ~clk;

  rom_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .dbg_ptr_o (dbg_ptr)
  );

  // waveform ROM model: synchronous read, 1-cycle latency
  logic [DW-1:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // reference model state
  int            m_ptr;
  logic [AW-1:0] m_last;
  int            m_pend;
  logic [DW-1:0] m_pend_data;
  int            last_g;

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs, check outputs at negedge, then advance the model over the posedge
  task automatic step(input logic rst, input logic [NREQ-1:0] v, input logic [NREQ*AW-1:0] a);
    int              g;
    logic [NREQ-1:0] sh;
    logic [NREQ-1:0] e_ready;
    logic [AW-1:0]   e_addr;
    logic [NREQ-1:0] e_rsp;
    reset     = rst;
    req_valid = v;
    req_addr  = a;
    @(negedge clk);
    g = -1;
    if (!rst) begin
      for (int k = 0; k < NREQ; k++) begin
        sh = v >> ((m_ptr + k) % NREQ);
        if (g < 0 && sh[0]) g = (m_ptr + k) % NREQ;
      end
    end
    e_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    e_addr  = (g >= 0) ? a[g*AW +: AW] : m_last;
    e_rsp   = (m_pend >= 0) ? (NREQ'(1) << m_pend) : '0;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("rom_addr",  32'(rom_addr),  32'(e_addr));
    check("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    check("ptr",       32'(dbg_ptr),   32'(m_ptr));
    if (m_pend >= 0) check("rsp_data", 32'(rsp_data), 32'(m_pend_data));
    if (rst) begin
      m_ptr  = 0;
      m_last = '0;
      m_pend = -1;
    end else if (g >= 0) begin
      m_ptr       = (g + 1) % NREQ;
      m_last      = e_addr;
      m_pend      = g;
      m_pend_data = rom_mem[e_addr];
    end else begin
      m_pend = -1;
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREQ*AW-1:0] pack3(input logic [AW-1:0] a2, input logic [AW-1:0] a1,
                                               input logic [AW-1:0] a0);
    return {a2, a1, a0};
  endfunction

  logic              cur_v [NREQ];
  logic [NREQ*AW-1:0] cur_a;
  logic [NREQ-1:0]   vv;

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'((i * 37 + 11) ^ (i >> 3));
    reset     = 1'b1;
    req_valid = '1;
    req_addr  = pack3(8'h11, 8'h22, 8'h33);
    m_ptr = 0; m_last = '0; m_pend = -1; m_pend_data = '0; last_g = -1;
    @(posedge clk);
    #1;

    // reset held with every requester valid
    step(1'b1, 3'b111, pack3(8'hA5, 8'h5A, 8'hC3));
    step(1'b1, 3'b111, pack3(8'h01, 8'h02, 8'h03));

    // single requester streaming 0x00..0x0F
    for (int i = 0; i < 16; i++)
      step(1'b0, 3'b001, pack3(8'($urandom), 8'($urandom), 8'(i)));

    // contention between req0 and req1
    for (int i = 0; i < 6; i++) step(1'b0, 3'b011, pack3(8'h00, 8'h80, 8'h10));

    // idle hold after a read of 0x3C
    step(1'b0, 3'b001, pack3(8'h00, 8'h00, 8'h3C));
    for (int i = 0; i < 3; i++) step(1'b0, 3'b000, pack3(8'($urandom), 8'($urandom), 8'($urandom)));
    check("idle_rom_addr", 32'(rom_addr), 32'h3C);

    // wrap: grant req1 to set ptr=2, then req0+req2 contend
    step(1'b0, 3'b010, pack3(8'h00, 8'h41, 8'h00));
    step(1'b0, 3'b101, pack3(8'h72, 8'h00, 8'h70));
    check("wrap_first_grant", 32'(last_g), 32'd2);
    step(1'b0, 3'b101, pack3(8'h72, 8'h00, 8'h70));
    check("wrap_second_grant", 32'(last_g), 32'd0);
    step(1'b0, 3'b000, pack3(8'h00, 8'h00, 8'h00));

    // reset in the same cycle req1 asks for 0xFF
    step(1'b0, 3'b001, pack3(8'h00, 8'h00, 8'h07));
    step(1'b1, 3'b010, pack3(8'h00, 8'hFF, 8'h00));
    step(1'b0, 3'b000, pack3(8'h00, 8'hFF, 8'h00));

    // randomized traffic honouring the hold-until-accepted rule
    for (int i = 0; i < NREQ; i++) cur_v[i] = 1'b0;
    cur_a = '0;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_v[i]) begin
          cur_v[i] = 1'($urandom_range(0, 1));
          cur_a[i*AW +: AW] = 8'($urandom);
        end
      end
      for (int i = 0; i < NREQ; i++) vv[i] = cur_v[i];
      step(($urandom_range(0, 29) == 0), vv, cur_a);
      if (last_g >= 0) cur_v[last_g] = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
